// File: rtl/peak_pkg.sv
// rtl/peak_pkg.sv - shared constants and types for the multi-task instruction fetch unit
package peak_pkg;
  localparam int TASK_NUM = 8;
  localparam int TASK_W   = 3;

  typedef enum logic [1:0] {
    DBG_RUN     = 2'd0,
    DBG_HALTING = 2'd1,
    DBG_HALTED  = 2'd2
  } dbg_state_e;

  typedef struct packed {
    logic              valid;
    logic [TASK_W-1:0] tid;
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              excpt;
  } fetch_bundle_t;

  typedef struct packed {
    logic              valid;
    logic [TASK_W-1:0] tid;
    logic [31:0]       pc;
  } inflight_t;

  function automatic logic [31:0] align4(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/peak_task_pc_file.sv
// rtl/peak_task_pc_file.sv - per-task PC array and enable bits, prioritized START > RDR > +4 update
module peak_task_pc_file
  import peak_pkg::*;
#(
  parameter logic [31:0]         RESET_VECTOR = 32'h0000_0000,
  parameter logic [TASK_NUM-1:0] BOOT_MASK    = 8'h01
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [TASK_W-1:0] rd_tid,
  output logic [31:0]       rd_pc,
  output logic              rd_en,
  input  logic              start_valid,
  input  logic [TASK_W-1:0] start_tid,
  input  logic [31:0]       start_pc,
  input  logic              stop_valid,
  input  logic [TASK_W-1:0] stop_tid,
  input  logic              rdr_valid,
  input  logic [TASK_W-1:0] rdr_tid,
  input  logic [31:0]       rdr_pc,
  input  logic              inc_valid,
  input  logic [TASK_W-1:0] inc_tid
);
  logic [31:0]         pc_q [TASK_NUM];
  logic [TASK_NUM-1:0] en_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < TASK_NUM; i++) begin
        pc_q[i] <= align4(RESET_VECTOR);
      end
      en_q <= BOOT_MASK;
    end else begin
      for (int i = 0; i < TASK_NUM; i++) begin
        if (start_valid && start_tid == TASK_W'(i)) begin
          pc_q[i] <= align4(start_pc);
        end else if (rdr_valid && rdr_tid == TASK_W'(i)) begin
          pc_q[i] <= align4(rdr_pc);
        end else if (inc_valid && inc_tid == TASK_W'(i)) begin
          pc_q[i] <= pc_q[i] + 32'd4;
        end
        // a stop in the same cycle as a start for the same task leaves it disabled
        if (stop_valid && stop_tid == TASK_W'(i)) begin
          en_q[i] <= 1'b0;
        end else if (start_valid && start_tid == TASK_W'(i)) begin
          en_q[i] <= 1'b1;
        end
      end
    end
  end

  assign rd_pc = pc_q[rd_tid];
  assign rd_en = en_q[rd_tid];
endmodule

// File: rtl/peak_fetch.sv
// rtl/peak_fetch.sv - barrel-scheduled 8-task instruction fetch with redirect, start/stop and debug halt
module peak_fetch
  import peak_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [7:0]  BOOT_MASK    = 8'h01
) (
  input  logic              CLK,
  input  logic              RST_N,
  output logic              I_MEM_VALID,
  output logic [31:0]       I_MEM_ADDR,
  input  logic              I_MEM_READY,
  input  logic [31:0]       I_MEM_RDATA,
  input  logic              I_MEM_EXCPT,
  input  logic              RDR_VALID,
  input  logic [TASK_W-1:0] RDR_TASK,
  input  logic [31:0]       RDR_PC,
  input  logic              START_VALID,
  input  logic [TASK_W-1:0] START_TASK,
  input  logic [31:0]       START_PC,
  input  logic              STOP_VALID,
  input  logic [TASK_W-1:0] STOP_TASK,
  input  logic              HALTREQ,
  input  logic              RESUMEREQ,
  output logic              HALT,
  output logic              RESUME,
  output logic              RUNNING,
  output logic              F_VALID,
  output logic [TASK_W-1:0] F_TASK,
  output logic [31:0]       F_PC,
  output logic [31:0]       F_INST,
  output logic              F_EXCPT
);
  logic [TASK_W-1:0] slot_q;
  logic [31:0]       slot_pc;
  logic              slot_en;
  inflight_t         inflight_q;
  fetch_bundle_t     f_q;
  dbg_state_e        state_q, state_d;
  logic              resume_q, resume_d;
  logic              kill;
  logic              rsp_take;
  logic              inc_valid;

  peak_task_pc_file #(
    .RESET_VECTOR(RESET_VECTOR),
    .BOOT_MASK   (BOOT_MASK)
  ) u_pc_file (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .rd_tid     (slot_q),
    .rd_pc      (slot_pc),
    .rd_en      (slot_en),
    .start_valid(START_VALID),
    .start_tid  (START_TASK),
    .start_pc   (START_PC),
    .stop_valid (STOP_VALID),
    .stop_tid   (STOP_TASK),
    .rdr_valid  (RDR_VALID),
    .rdr_tid    (RDR_TASK),
    .rdr_pc     (RDR_PC),
    .inc_valid  (inc_valid),
    .inc_tid    (inflight_q.tid)
  );

  assign I_MEM_VALID = RST_N && slot_en && (state_q == DBG_RUN);
  assign I_MEM_ADDR  = align4(slot_pc);

  // a redirect aimed at the task whose response is arriving squashes that response
  assign kill      = RDR_VALID && (RDR_TASK == inflight_q.tid);
  assign rsp_take  = inflight_q.valid && I_MEM_READY && !kill;
  assign inc_valid = rsp_take && !I_MEM_EXCPT;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      slot_q     <= '0;
      inflight_q <= '0;
      f_q        <= '0;
    end else begin
      slot_q           <= slot_q + TASK_W'(1);
      inflight_q.valid <= I_MEM_VALID;
      inflight_q.tid   <= slot_q;
      inflight_q.pc    <= I_MEM_ADDR;
      f_q.valid        <= rsp_take;
      if (rsp_take) begin
        f_q.tid   <= inflight_q.tid;
        f_q.pc    <= inflight_q.pc;
        f_q.inst  <= I_MEM_EXCPT ? 32'h0 : I_MEM_RDATA;
        f_q.excpt <= I_MEM_EXCPT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= DBG_RUN;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    resume_d = 1'b0;
    case (state_q)
      DBG_RUN: begin
        if (HALTREQ) state_d = DBG_HALTING;
      end
      DBG_HALTING: begin
        if (!inflight_q.valid) state_d = DBG_HALTED;
      end
      DBG_HALTED: begin
        if (!HALTREQ && RESUMEREQ) begin
          state_d  = DBG_RUN;
          resume_d = 1'b1;
        end
      end
      default: state_d = DBG_RUN;
    endcase
  end

  assign HALT    = (state_q == DBG_HALTED);
  assign RUNNING = (state_q == DBG_RUN);
  assign RESUME  = resume_q;

  assign F_VALID = f_q.valid;
  assign F_TASK  = f_q.tid;
  assign F_PC    = f_q.pc;
  assign F_INST  = f_q.inst;
  assign F_EXCPT = f_q.excpt;
endmodule

// File: doc/peak_fetch.md
PEAK_FETCH -- requirements
Module: peak_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000; boot PC of every task.
REQ-002 Parameter BOOT_MASK, default 8'h01; tasks enabled after reset.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RST_N  in  1  reset, synchronous, active-low.
REQ-005 I_MEM_VALID  out  1  fetch request in the issue cycle.
REQ-006 I_MEM_ADDR  out  32  fetch address; bits [1:0] always 0.
REQ-007 I_MEM_READY  in  1  response valid, sampled one cycle after issue.
REQ-008 I_MEM_RDATA  in  32  instruction word, qualified by I_MEM_READY.
REQ-009 I_MEM_EXCPT  in  1  fetch access fault, qualified by I_MEM_READY.
REQ-010 RDR_VALID / RDR_TASK / RDR_PC  in  1/3/32  PC redirect from EX (branch, jump, trap).
REQ-011 START_VALID / START_TASK / START_PC  in  1/3/32  enable a task at a PC.
REQ-012 STOP_VALID / STOP_TASK  in  1/3  disable a task.
REQ-013 HALTREQ, RESUMEREQ  in  1  debug halt and resume requests.
REQ-014 HALT, RESUME, RUNNING  out  1  debug status.
REQ-015 F_VALID / F_TASK / F_PC / F_INST / F_EXCPT  out  1/3/32/32/1  registered fetch bundle to decode.

Function
REQ-016 The 3-bit issue slot counter SHALL increment every cycle and wrap 7->0; the slot value is the current task.
REQ-017 Issue cycle: I_MEM_ADDR SHALL equal pc[slot], and I_MEM_VALID SHALL be en[slot] & (state==RUN).
REQ-018 Response cycle (issue+1): the block SHALL record whether the fetch is in flight, together with its task and PC.
REQ-019 Response with READY=1 and EXCPT=0: on the next edge, set F_VALID=1, F_TASK and F_PC to the issued values, F_INST=RDATA, F_EXCPT=0, and pc[task] += 4 (mod 2^32).
REQ-020 Response with READY=1 and EXCPT=1: F_VALID=1, F_EXCPT=1, F_INST=0; pc unchanged.
REQ-021 Response with READY=0: F_VALID=0 and pc unchanged, so the task retries at its next slot.
REQ-022 Latency: issue to F_VALID is exactly 2 cycles.
REQ-023 When RDR_VALID is high, pc[RDR_TASK] SHALL be loaded with {RDR_PC[31:2],2'b00}. This has priority over the +4 update.
REQ-024 When RDR_TASK matches the in-flight task in the same cycle, the in-flight fetch SHALL be killed (F_VALID=0).
REQ-025 START SHALL set en[START_TASK]=1 and pc={START_PC[31:2],2'b00}. START has priority over RDR for the same task.
REQ-026 STOP SHALL clear en[STOP_TASK]. If START and STOP name the same task in the same cycle, STOP wins. An in-flight fetch of the stopped task still completes.
REQ-027 Debug FSM states: RUN, HALTING, HALTED.
  - RUN -> HALTING on HALTREQ.
  - HALTING -> HALTED when no fetch is in flight.
  - HALTED -> RUN on RESUMEREQ.
  - In HALTED, HALTREQ has priority over a simultaneous RESUMEREQ.
REQ-028 HALT SHALL be 1 in HALTED. RESUME SHALL pulse for one cycle on HALTED->RUN. RUNNING SHALL be 1 in RUN.
REQ-029 PCs, redirects and start/stop SHALL continue to update while the FSM is in HALTED.

Reset
REQ-030 While RST_N=0 at an edge, the block SHALL set:
  - slot=0;
  - pc[all]=RESET_VECTOR;
  - en=BOOT_MASK;
  - state=RUN;
  - in-flight cleared;
  - F_VALID=0, F_TASK=0, F_PC=0, F_INST=0, F_EXCPT=0;
  - HALT=0, RESUME=0, RUNNING=1.
REQ-031 Reset asserted mid-fetch SHALL discard the in-flight response. I_MEM_VALID SHALL be 0 while RST_N=0.

Structure
REQ-032 Package peak_pkg SHALL hold TASK_NUM=8, TASK_W=3, the debug-state enum and the fetch-bundle struct.
REQ-033 Sub-module peak_task_pc_file SHALL hold the 8x32 PC array and the enable bits. It provides one read port and the prioritized update (START > RDR > +4).

Verification
REQ-034 Reset, BOOT_MASK=01, READY=1 held. Required: I_MEM_VALID only in slot 0; addresses 0x0, then 0x4 eight cycles later. F_VALID two cycles after each issue, with F_TASK=0.
REQ-035 START task 3 at 0x1002. Required: slot-3 issue address 0x1000; F_PC=0x1000; next slot-3 issue 0x1004.
REQ-036 READY=0 on task 0's response at PC 0x8. Required: F_VALID=0; task 0 re-issues 0x8 eight cycles later.
REQ-037 RDR task 0 to 0x200 in the cycle task 0's fetch is in flight. Required: that fetch is killed; next issue 0x200.
REQ-038 EXCPT=1 with READY=1 at PC 0x10. Required: F_EXCPT=1, F_INST=0; re-issue 0x10.
REQ-039 HALTREQ during an in-flight fetch. Required: HALT one cycle after the fetch completes, no further I_MEM_VALID; RESUMEREQ then gives a one-cycle RESUME and issue restarts at the current slot.
